pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Registered fetch-address sequencer: step, branch, jump, call/return with fixed priority.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
    parameter int unsigned           WIDTH     = 32,
    parameter int unsigned           STEP      = 4,
    parameter logic [WIDTH-1:0]      RESET_VEC = '0,
    parameter int unsigned           RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_en,
    input  logic [WIDTH-1:0] br_off,
    input  logic             jmp_en,
    input  logic [WIDTH-1:0] jmp_addr,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    logic [WIDTH-1:0] pc_q, pc_d;

    assign pc     = pc_q;
    assign pc_seq = pc_q + WIDTH'(STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [PtrW-1:0]  top_q, top_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push;

    assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));
    assign ras_empty = (cnt_q == '0);
    assign ras_err   = err_q;

    always_comb begin
        pc_d  = pc_seq;
        top_d = top_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        push  = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret_en) begin
            if (!ras_empty) begin
                pc_d  = ras_mem_q[top_q];
                top_d = top_q - PtrW'(1);
                cnt_d = cnt_q - CntW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (call_en) begin
            pc_d  = jmp_addr;
            push  = 1'b1;
            // Circular buffer: on overflow the new top lands on the oldest entry.
            top_d = top_q + PtrW'(1);
            if (ras_full) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (jmp_en) begin
            pc_d = jmp_addr;
        end else if (br_en) begin
            pc_d = pc_seq + br_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_mem_q[top_d] <= pc_seq;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ret_en ^ (RAS_DEPTH > 1);

    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_err   = 1'b0;

    always_comb begin
        pc_d = pc_seq;
        if (stall) begin
            pc_d = pc_q;
        end else if (call_en || jmp_en) begin
            pc_d = jmp_addr;
        end else if (br_en) begin
            pc_d = pc_seq + br_off;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// against a queue-based reference model (RAS part active when PC_RAS_EN is defined).
module tb_pc_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0, stall = 1'b0, br_en = 1'b0, jmp_en = 1'b0;
    logic        call_en = 1'b0, ret_en = 1'b0;
    logic [31:0] br_off = '0, jmp_addr = '0;
    logic [31:0] pc, pc_seq;
    logic        ras_full, ras_empty, ras_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [31:0] pc_m;
    logic [31:0] ras_m[$];
    logic        err_m;

    pc_sequencer #(
        .WIDTH    (WIDTH),
        .STEP     (4),
        .RESET_VEC(RVEC),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .br_en    (br_en),
        .br_off   (br_off),
        .jmp_en   (jmp_en),
        .jmp_addr (jmp_addr),
        .call_en  (call_en),
        .ret_en   (ret_en),
        .pc       (pc),
        .pc_seq   (pc_seq),
        .ras_full (ras_full),
        .ras_empty(ras_empty),
        .ras_err  (ras_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ras_on();
`ifdef PC_RAS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        if (rst) begin
            pc_m  = RVEC;
            ras_m.delete();
            err_m = 1'b0;
        end else begin
            err_m = 1'b0;
            if (stall) begin
                // hold
            end else if (ret_en && ras_on()) begin
                if (ras_m.size() > 0) begin
                    pc_m = ras_m.pop_back();
                end else begin
                    pc_m  = pc_m + 32'd4;
                    err_m = 1'b1;
                end
            end else if (call_en) begin
                if (ras_on()) begin
                    if (ras_m.size() == DEPTH) begin
                        void'(ras_m.pop_front());
                        err_m = 1'b1;
                    end
                    ras_m.push_back(pc_m + 32'd4);
                end
                pc_m = jmp_addr;
            end else if (jmp_en) begin
                pc_m = jmp_addr;
            end else if (br_en) begin
                pc_m = pc_m + 32'd4 + br_off;
            end else begin
                pc_m = pc_m + 32'd4;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] off,
                       input logic j, input logic [31:0] a, input logic c, input logic rt);
        rst = r; stall = s; br_en = b; br_off = off;
        jmp_en = j; jmp_addr = a; call_en = c; ret_en = rt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pc", pc, pc_m);
        check("pc_seq", pc_seq, pc_m + 32'd4);
        check("ras_full", {31'd0, ras_full}, {31'd0, ras_on() && ras_m.size() == DEPTH});
        check("ras_empty", {31'd0, ras_empty}, {31'd0, !ras_on() || ras_m.size() == 0});
        check("ras_err", {31'd0, ras_err}, {31'd0, err_m});
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic jump(input logic [31:0] a);
        cyc(0, 0, 0, 0, 1, a, 0, 0);
    endtask
    task automatic call(input logic [31:0] a);
        cyc(0, 0, 0, 0, 0, a, 1, 0);
    endtask
    task automatic ret();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        pc_m  = RVEC;
        err_m = 1'b0;

        // Reset and free-running sequence
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_pc", pc, 32'h100);
        check("rst_empty", {31'd0, ras_empty}, 32'd1);
        idle(); check("seq1", pc, 32'h104);
        idle(); check("seq2", pc, 32'h108);
        idle(); check("seq3", pc, 32'h10C);

        // Backward branch, then jump beats branch
        jump(32'h200);
        cyc(0, 0, 1, -32'sd8, 0, 0, 0, 0); check("br_neg", pc, 32'h1FC);
        cyc(0, 0, 1, 32'h40, 1, 32'h4000, 0, 0); check("jmp_wins", pc, 32'h4000);

        // Stall overrides a pending jump
        jump(32'h300);
        cyc(0, 1, 0, 0, 1, 32'h9000, 0, 0); check("stall1", pc, 32'h300);
        cyc(0, 1, 0, 0, 1, 32'h9000, 0, 0); check("stall2", pc, 32'h300);
        idle(); check("stall_rel", pc, 32'h304);

`ifdef PC_RAS_EN
        // Nested call/return, then underflow
        jump(32'h10);
        call(32'h80); call(32'h90); call(32'h100);
        ret(); check("ret1", pc, 32'h94);
        ret(); check("ret2", pc, 32'h84);
        ret(); check("ret3", pc, 32'h14);
        check("ret_empty", {31'd0, ras_empty}, 32'd1);
        ret(); check("under_pc", pc, 32'h18);
        check("under_err", {31'd0, ras_err}, 32'd1);
        idle(); check("err_clr", {31'd0, ras_err}, 32'd0);

        // Overflow: oldest entry dropped
        for (int i = 1; i <= 5; i++) begin
            call(32'h1000 * i);
            if (i == 4) check("full4", {31'd0, ras_full}, 32'd1);
            if (i == 5) check("over_err", {31'd0, ras_err}, 32'd1);
        end
        ret(); check("ovr_ret1", pc, 32'h4004);
        ret(); check("ovr_ret2", pc, 32'h3004);
        ret(); check("ovr_ret3", pc, 32'h2004);
        ret(); check("ovr_ret4", pc, 32'h1004);
        check("ovr_empty", {31'd0, ras_empty}, 32'd1);

        // Call immediately followed by return
        jump(32'h700); call(32'h800); ret(); check("call_ret", pc, 32'h704);
`else
        jump(32'h10);
        call(32'h80); check("nr_call", pc, 32'h80);
        ret(); check("nr_ret", pc, 32'h84);
`endif

        // Address wrap, then reset beating a call
        jump(32'hFFFF_FFFC);
        idle(); check("wrap", pc, 32'h0);
        call(32'h500);
        cyc(1, 0, 0, 0, 0, 32'h600, 1, 0); check("rst_call", pc, 32'h100);
        check("rst_call_empty", {31'd0, ras_empty}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] off, addr;
            off  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
            addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom();
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, off, $urandom_range(0, 7) == 0, addr,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
